// File: rtl/axi_shim_arbiter.sv
// rtl/axi_shim_arbiter.sv - round-robin requester-to-shim arbiter with ID-based response routing
// One arbitration channel is instantiated per direction (read and write).

module axi_shim_arbiter_chan #(
  parameter int NumPorts       = 3,
  parameter int AxiIdWidth     = 4,
  parameter int MaxOutstanding = 4,
  parameter int CmdWidth       = 80
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NumPorts-1:0]                req,
  input  logic [NumPorts-1:0][CmdWidth-1:0]  cmd,
  output logic [NumPorts-1:0]                gnt,
  output logic [NumPorts-1:0]                valid,
  input  logic [NumPorts-1:0]                rdy,
  output logic                               shim_req,
  input  logic                               shim_gnt,
  output logic [CmdWidth-1:0]                shim_cmd,
  output logic [AxiIdWidth-1:0]              shim_id,
  input  logic                               shim_valid,
  input  logic                               shim_last,
  input  logic [AxiIdWidth-1:0]              shim_rsp_id,
  output logic                               shim_rdy,
  output logic                               unmapped
);

  localparam int IdxW = $clog2(NumPorts);
  localparam int CntW = $clog2(MaxOutstanding + 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            state;
  logic [IdxW-1:0]   winner;
  logic [IdxW-1:0]   rr_ptr;
  logic [IdxW-1:0]   pick;
  logic [IdxW-1:0]   sel_idx;
  logic [CntW-1:0]   outstanding;
  logic              active;
  logic              mapped;
  logic              valid_eff;
  logic              inc;
  logic              dec;

  // First requesting port at or after ptr, wrapping modulo NumPorts.
  function automatic logic [IdxW-1:0] rr_pick(input logic [NumPorts-1:0] r,
                                              input logic [IdxW-1:0] ptr);
    logic [IdxW-1:0] idx;
    rr_pick = ptr;
    for (int k = NumPorts - 1; k >= 0; k--) begin
      idx = IdxW'((int'(ptr) + k) % NumPorts);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign pick    = rr_pick(req, rr_ptr);
  assign mapped  = {1'b0, shim_rsp_id} < (AxiIdWidth + 1)'(NumPorts);
  assign sel_idx = shim_rsp_id[IdxW-1:0];

  // Responses are masked for the cycle following a reset edge so valids read 0.
  assign valid_eff = shim_valid & active;
  assign valid     = (valid_eff && mapped) ? (NumPorts'(1) << sel_idx) : '0;
  assign shim_rdy  = mapped ? rdy[sel_idx] : 1'b1;
  assign unmapped  = valid_eff && !mapped;

  assign inc = (state == HOLD) && shim_gnt;
  assign dec = valid_eff && shim_rdy && shim_last;
  assign gnt = inc ? (NumPorts'(1) << winner) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      winner      <= '0;
      rr_ptr      <= '0;
      outstanding <= '0;
      shim_req    <= 1'b0;
      shim_cmd    <= '0;
      shim_id     <= '0;
      active      <= 1'b0;
    end else begin
      active <= 1'b1;
      case (state)
        IDLE: begin
          if (|req && outstanding < CntW'(MaxOutstanding)) begin
            winner   <= pick;
            shim_cmd <= cmd[pick];
            shim_id  <= AxiIdWidth'(pick);
            shim_req <= 1'b1;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (shim_gnt) begin
            shim_req <= 1'b0;
            rr_ptr   <= (winner == IdxW'(NumPorts - 1)) ? '0 : winner + 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      case ({inc, dec})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  hold_req_a: assert property (@(posedge clk) disable iff (!rst_n)
    (state == HOLD) |-> req[winner]);
  no_underflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(dec && !inc && outstanding == '0));
  no_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(inc && !dec && outstanding == CntW'(MaxOutstanding)));

endmodule

module axi_shim_arbiter #(
  parameter int NumPorts       = 3,
  parameter int AxiIdWidth     = 4,
  parameter int MaxOutstanding = 4,
  parameter int RdCmdWidth     = 80,
  parameter int WrCmdWidth     = 400
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumPorts-1:0]                 req_rd_req_i,
  input  logic [NumPorts-1:0][RdCmdWidth-1:0] req_rd_cmd_i,
  output logic [NumPorts-1:0]                 req_rd_gnt_o,
  output logic [NumPorts-1:0]                 req_rd_valid_o,
  input  logic [NumPorts-1:0]                 req_rd_rdy_i,
  output logic                                shim_rd_req_o,
  input  logic                                shim_rd_gnt_i,
  output logic [RdCmdWidth-1:0]               shim_rd_cmd_o,
  output logic [AxiIdWidth-1:0]               shim_rd_id_o,
  input  logic                                shim_rd_valid_i,
  input  logic                                shim_rd_last_i,
  input  logic [AxiIdWidth-1:0]               shim_rd_id_i,
  output logic                                shim_rd_rdy_o,
  input  logic [NumPorts-1:0]                 req_wr_req_i,
  input  logic [NumPorts-1:0][WrCmdWidth-1:0] req_wr_cmd_i,
  output logic [NumPorts-1:0]                 req_wr_gnt_o,
  output logic [NumPorts-1:0]                 req_wr_valid_o,
  input  logic [NumPorts-1:0]                 req_wr_rdy_i,
  output logic                                shim_wr_req_o,
  input  logic                                shim_wr_gnt_i,
  output logic [WrCmdWidth-1:0]               shim_wr_cmd_o,
  output logic [AxiIdWidth-1:0]               shim_wr_id_o,
  input  logic                                shim_wr_valid_i,
  input  logic [AxiIdWidth-1:0]               shim_wr_id_i,
  output logic                                shim_wr_rdy_o,
  output logic                                err_o
);

  logic rd_unmapped;
  logic wr_unmapped;

  axi_shim_arbiter_chan #(
    .NumPorts(NumPorts), .AxiIdWidth(AxiIdWidth),
    .MaxOutstanding(MaxOutstanding), .CmdWidth(RdCmdWidth)
  ) u_rd (
    .clk(clk_i), .rst_n(rst_ni),
    .req(req_rd_req_i), .cmd(req_rd_cmd_i), .gnt(req_rd_gnt_o),
    .valid(req_rd_valid_o), .rdy(req_rd_rdy_i),
    .shim_req(shim_rd_req_o), .shim_gnt(shim_rd_gnt_i),
    .shim_cmd(shim_rd_cmd_o), .shim_id(shim_rd_id_o),
    .shim_valid(shim_rd_valid_i), .shim_last(shim_rd_last_i),
    .shim_rsp_id(shim_rd_id_i), .shim_rdy(shim_rd_rdy_o),
    .unmapped(rd_unmapped)
  );

  // Every write response is a single beat, so it always retires a transaction.
  axi_shim_arbiter_chan #(
    .NumPorts(NumPorts), .AxiIdWidth(AxiIdWidth),
    .MaxOutstanding(MaxOutstanding), .CmdWidth(WrCmdWidth)
  ) u_wr (
    .clk(clk_i), .rst_n(rst_ni),
    .req(req_wr_req_i), .cmd(req_wr_cmd_i), .gnt(req_wr_gnt_o),
    .valid(req_wr_valid_o), .rdy(req_wr_rdy_i),
    .shim_req(shim_wr_req_o), .shim_gnt(shim_wr_gnt_i),
    .shim_cmd(shim_wr_cmd_o), .shim_id(shim_wr_id_o),
    .shim_valid(shim_wr_valid_i), .shim_last(1'b1),
    .shim_rsp_id(shim_wr_id_i), .shim_rdy(shim_wr_rdy_o),
    .unmapped(wr_unmapped)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_o <= 1'b0;
    end else if (rd_unmapped || wr_unmapped) begin
      err_o <= 1'b1;
    end
  end

endmodule

// File: doc/axi_shim_arbiter.md
AXI_SHIM_ARBITER -- requirements
Module: axi_shim_arbiter

Interface
REQ-001 SHALL have parameter NumPorts, default 3: number of requesters, range 2..(2**AxiIdWidth).
REQ-002 SHALL have parameter AxiIdWidth, default 4: shim transaction ID width, must be >= 2.
REQ-003 SHALL have parameter MaxOutstanding, default 4: maximum accepted-but-unanswered transactions per channel.
REQ-004 SHALL have parameters RdCmdWidth and WrCmdWidth, defaults 80 and 400: opaque bundled command widths (addr/blen/size/lock for reads; addr/data/be/user/blen/size/lock/atop for writes).
REQ-005 SHALL have port clk_i, in, 1: the single clock.
REQ-006 SHALL have port rst_ni, in, 1: reset, synchronous and active-low.
REQ-007 SHALL have port req_rd_req_i, in, NumPorts: per-requester read request.
REQ-008 SHALL have port req_rd_cmd_i, in, NumPorts x RdCmdWidth: per-requester read command.
REQ-009 SHALL have port req_rd_gnt_o, out, NumPorts: read request accepted.
REQ-010 SHALL have port req_rd_valid_o, out, NumPorts: routed read-beat valid.
REQ-011 SHALL have port req_rd_rdy_i, in, NumPorts: requester read-beat ready.
REQ-012 SHALL have port shim_rd_req_o, out, 1, and port shim_rd_gnt_i, in, 1: shim read request and grant.
REQ-013 SHALL have port shim_rd_cmd_o, out, RdCmdWidth, and port shim_rd_id_o, out, AxiIdWidth: muxed read command and ID.
REQ-014 SHALL have ports shim_rd_valid_i, in, 1; shim_rd_last_i, in, 1; shim_rd_id_i, in, AxiIdWidth; shim_rd_rdy_o, out, 1: read response handshake.
REQ-015 SHALL have write-channel ports req_wr_req_i, req_wr_cmd_i (NumPorts x WrCmdWidth), req_wr_gnt_o, req_wr_valid_o, req_wr_rdy_i, shim_wr_req_o, shim_wr_gnt_i, shim_wr_cmd_o, shim_wr_id_o, shim_wr_valid_i, shim_wr_id_i and shim_wr_rdy_o, mirroring REQ-007..REQ-014 without a last signal.
REQ-016 SHALL have port err_o, out, 1: sticky flag for a response carrying an unmapped ID.

Function
REQ-017 Read and write channels SHALL arbitrate independently with identical logic; REQ-018..REQ-026 apply to each channel.
REQ-018 Each channel SHALL run a two-state FSM: IDLE and HOLD.
REQ-019 In IDLE, with any req set and outstanding < MaxOutstanding, the block SHALL register the winner (round-robin from rr_ptr) and move to HOLD; shim_*_req_o SHALL be 0 in IDLE.
REQ-020 In HOLD, the block SHALL drive shim_*_req_o=1, shim_*_cmd_o=cmd[winner], and shim_*_id_o=winner zero-extended, all stable until grant.
REQ-021 On shim_*_gnt_i in HOLD, the block SHALL assert req_*_gnt_o[winner] in the same cycle (combinational), increment outstanding, set rr_ptr=(winner+1) mod NumPorts, and return to IDLE.
REQ-022 Request-to-shim latency SHALL be 1 cycle; the minimum back-to-back issue interval SHALL be 2 cycles.
REQ-023 Requesters SHALL hold req and cmd until granted; a req drop in HOLD is a protocol violation flagged by a simulation assertion, and the block SHALL keep presenting the registered winner.
REQ-024 Response routing: p=shim_*_id_i; when p<NumPorts, req_*_valid_o[p]=shim_*_valid_i, other valids 0, and shim_*_rdy_o=req_*_rdy_i[p].
REQ-025 When p>=NumPorts, the block SHALL drive shim_*_rdy_o=1, all req_*_valid_o=0, and set err_o on valid.
REQ-026 Outstanding SHALL decrement on read valid&rdy&last or write valid&rdy; simultaneous increment and decrement SHALL leave it unchanged; the counter width SHALL be clog2(MaxOutstanding+1) and it SHALL never wrap (assertion).
REQ-027 Response data, user and exokay fields SHALL be broadcast outside this block; only valid/ready SHALL be routed here.

Reset
REQ-028 With rst_ni low at a clock edge, both FSMs SHALL go to IDLE, rr_ptr=0, outstanding=0, err_o=0, and all gnt/req/valid outputs SHALL read 0 from the next cycle, including a reset taken mid-HOLD.
REQ-029 shim_*_rdy_o SHALL remain combinational per REQ-024/025 during reset.

Verification
REQ-030 Ports 0,1,2 request reads continuously with shim_rd_gnt_i=1 -> grants in order 0,1,2,0 on every other cycle, with shim_rd_id_o = 0,1,2,0.
REQ-031 MaxOutstanding=4, no responses -> exactly 4 grants, then shim_rd_req_o stays 0; one last beat returned -> a fifth grant occurs.
REQ-032 Read response with shim_rd_id_i=1, req_rd_rdy_i=3'b010 -> req_rd_valid_o=3'b010 and shim_rd_rdy_o=1; with rdy 3'b101 -> shim_rd_rdy_o=0.
REQ-033 Response with shim_wr_id_i=7, NumPorts=3 -> shim_wr_rdy_o=1, no valids, err_o=1 until reset.
REQ-034 Reset asserted in HOLD with shim_wr_gnt_i=0 -> next cycle shim_wr_req_o=0, outstanding=0, and the first post-reset grant goes to the lowest requesting port.
